// File: rtl/ecg_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ecg_ram_arbiter                                              |
// | Description : Shares the single-port ECG sample RAM between a buffered     |
// |               sample writer and the VGA waveform column reader.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ecg_ram_arbiter #(
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'h801,
    parameter int                DEPTH      = 640,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [11:0]       wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [9:0]        rd_index,
    output logic              rd_valid,
    output logic [11:0]       rd_data,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [9:0]        wr_ptr,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int                c_ptr_w     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0]  c_fifo_full = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]  c_cnt_one   = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [10:0]       c_depth     = 11'(DEPTH);
    localparam logic [9:0]        c_last_slot = 10'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [11:0]         r_fifo_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_fifo_rd_ptr;
    logic [c_ptr_w-1:0]  r_fifo_wr_ptr;
    logic [c_ptr_w:0]    r_fifo_count;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    logic [9:0]          r_wr_ptr;
    logic [9:0]          r_snap;
    logic [9:0]          w_wr_ptr_inc;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_wdata;
    logic [ADDR_W-1:0]   w_ram_addr_next;
    logic [31:0]         w_ram_wdata_next;

    logic                w_rd_in_range;
    logic                w_rd_hit;
    logic [10:0]         w_rd_sum;
    logic [10:0]         w_rd_wrapped;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [ADDR_W-1:0]   w_wr_addr;

    logic [1:0]          r_rd_pipe;
    logic [1:0]          r_rd_oor;
    logic                r_rd_valid;
    logic [11:0]         r_rd_data;
    logic                r_overflow;
    logic                w_unused_rdata;

    // Occupancy is registered, so a same-cycle pop never lets a full FIFO accept.
    assign w_full   = (r_fifo_count == c_fifo_full);
    assign w_empty  = (r_fifo_count == '0);
    assign w_push   = wr_valid && !w_full;

    assign w_rd_in_range = ({1'b0, rd_index} < c_depth);
    assign w_rd_hit      = rd_req && w_rd_in_range;
    assign w_rd_sum      = {1'b0, r_snap} + {1'b0, rd_index};
    assign w_rd_wrapped  = (w_rd_sum >= c_depth) ? (w_rd_sum - c_depth) : w_rd_sum;
    assign w_rd_addr     = BASE_ADDR + ADDR_W'(w_rd_wrapped[9:0]);
    assign w_wr_addr     = BASE_ADDR + ADDR_W'(r_wr_ptr);
    assign w_wr_ptr_inc  = (r_wr_ptr == c_last_slot) ? 10'd0 : (r_wr_ptr + 10'd1);

    always_comb begin
        w_state_next     = ST_IDLE;
        w_pop            = 1'b0;
        w_ram_addr_next  = r_ram_addr;
        w_ram_wdata_next = r_ram_wdata;
        if (w_rd_hit) begin
            w_state_next    = ST_READ;
            w_ram_addr_next = w_rd_addr;
        end else if (!w_empty) begin
            w_state_next     = ST_WRITE;
            w_pop            = 1'b1;
            w_ram_addr_next  = w_wr_addr;
            w_ram_wdata_next = {20'd0, r_fifo_mem[r_fifo_rd_ptr]};
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_mem[r_fifo_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fifo_rd_ptr <= '0;
            r_fifo_wr_ptr <= '0;
            r_fifo_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr_ptr <= r_fifo_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_fifo_rd_ptr <= r_fifo_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_cnt_one;
                2'b01:   r_fifo_count <= r_fifo_count - c_cnt_one;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_wr_ptr    <= '0;
            r_snap      <= '0;
            r_rd_pipe   <= '0;
            r_rd_oor    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ram_addr  <= w_ram_addr_next;
            r_ram_wdata <= w_ram_wdata_next;
            if (w_pop) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            // Pre-increment pointer: column 0 shows the oldest sample.
            if (frame_start) begin
                r_snap <= r_wr_ptr;
            end
            r_rd_pipe  <= {r_rd_pipe[0], rd_req};
            r_rd_oor   <= {r_rd_oor[0], rd_req && !w_rd_in_range};
            r_rd_valid <= r_rd_pipe[1];
            r_rd_data  <= (r_rd_pipe[1] && !r_rd_oor[1]) ? ram_rdata[11:0] : 12'd0;
            if (wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_unused_rdata = ^ram_rdata[31:12];

    assign wr_ready  = !w_full;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = (r_state == ST_WRITE);
    assign ram_wdata = r_ram_wdata;
    assign wr_ptr    = r_wr_ptr;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
